// File: rtl/neighbor_output_processor.sv
`default_nettype none
// ============================================================================
// Module      : neighbor_output_processor
// Description : Scans the halo cells of the local accumulator tile and forwards
//               each non-zero value to the owning neighbour, translating its
//               coordinates into that neighbour's tile frame.
// Revision    : 1.0 - initial release
// ============================================================================
module neighbor_output_processor #(
    parameter int BANK_COUNT = 32,
    parameter int TILE_SIZE  = 256,
    parameter int TILE_DIM   = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [2:0]                            kernel_size,
    input  logic                                  channel_group_done,
    output logic [$clog2(BANK_COUNT)-1:0]         buffer_bank_read,
    output logic [$clog2(TILE_SIZE)-1:0]          buffer_bank_entry,
    input  logic [7:0]                            buffer_data_read,
    input  logic [7:0]                            neighbor_cts,
    input  logic [7:0]                            neighbor_exchange_done,
    output logic [7:0][7:0]                       neighbor_output_value,
    output logic [7:0][$clog2(TILE_SIZE)-1:0]     neighbor_output_row,
    output logic [7:0][$clog2(TILE_SIZE)-1:0]     neighbor_output_column,
    output logic [7:0]                            neighbor_output_write_enable,
    output logic                                  exchange_done,
    output logic                                  cycle_done
);
    localparam int c_BANK_W  = $clog2(BANK_COUNT);
    localparam int c_ENTRY_W = $clog2(TILE_SIZE);

    localparam logic [c_ENTRY_W-1:0] c_TILE_DIM = c_ENTRY_W'(TILE_DIM);
    localparam logic [c_ENTRY_W-1:0] c_ONE      = c_ENTRY_W'(1);

    localparam logic [1:0] c_ZONE_LO  = 2'd0;  // top row / left column
    localparam logic [1:0] c_ZONE_MID = 2'd1;
    localparam logic [1:0] c_ZONE_HI  = 2'd2;  // bottom row / right column

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_CAPTURE  = 3'd2,
        S_XMIT     = 3'd3,
        S_WAIT_NBR = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_ENTRY_W-1:0]   r_half;
    logic [c_ENTRY_W-1:0]   r_width;
    logic [c_ENTRY_W-1:0]   r_row;
    logic [c_ENTRY_W-1:0]   r_col;
    logic [2:0]             r_dir;
    logic [7:0]             r_value;
    logic [c_ENTRY_W-1:0]   r_out_row;
    logic [c_ENTRY_W-1:0]   r_out_col;

    logic [c_ENTRY_W-1:0]   w_half;
    logic [c_ENTRY_W-1:0]   w_index;
    logic [1:0]             w_row_zone;
    logic [1:0]             w_col_zone;
    logic [2:0]             w_dir;
    logic [c_ENTRY_W-1:0]   w_next_row;
    logic [c_ENTRY_W-1:0]   w_next_col;
    logic                   w_last;
    logic                   w_advance;
    logic                   w_capture;

    function automatic logic [1:0] zone_of(input logic [c_ENTRY_W-1:0] pos,
                                           input logic [c_ENTRY_W-1:0] half);
        if (pos < half)
            return c_ZONE_LO;
        else if (pos >= c_TILE_DIM + half)
            return c_ZONE_HI;
        else
            return c_ZONE_MID;
    endfunction

    function automatic logic [c_ENTRY_W-1:0] translate(input logic [c_ENTRY_W-1:0] pos,
                                                       input logic [1:0] zone);
        case (zone)
            c_ZONE_LO: return pos + c_TILE_DIM;
            c_ZONE_HI: return pos - c_TILE_DIM;
            default:   return pos;
        endcase
    endfunction

    assign w_half     = c_ENTRY_W'(kernel_size >> 1);
    // Index always fits: W*W <= TILE_SIZE, so truncation is exact.
    assign w_index    = r_row * r_width + r_col;
    assign w_row_zone = zone_of(r_row, r_half);
    assign w_col_zone = zone_of(r_col, r_half);
    assign w_last     = (r_row == r_width - c_ONE) && (r_col == r_width - c_ONE);

    always_comb begin
        w_dir = 3'd0;
        case ({w_row_zone, w_col_zone})
            {c_ZONE_LO,  c_ZONE_MID}: w_dir = 3'd0;
            {c_ZONE_LO,  c_ZONE_HI }: w_dir = 3'd1;
            {c_ZONE_MID, c_ZONE_HI }: w_dir = 3'd2;
            {c_ZONE_HI,  c_ZONE_HI }: w_dir = 3'd3;
            {c_ZONE_HI,  c_ZONE_MID}: w_dir = 3'd4;
            {c_ZONE_HI,  c_ZONE_LO }: w_dir = 3'd5;
            {c_ZONE_MID, c_ZONE_LO }: w_dir = 3'd6;
            {c_ZONE_LO,  c_ZONE_LO }: w_dir = 3'd7;
            default:                  w_dir = 3'd0;
        endcase
    end

    // Middle rows skip straight over the interior to the right-hand halo.
    always_comb begin
        w_next_row = r_row;
        w_next_col = r_col + c_ONE;
        if (r_col == r_width - c_ONE) begin
            w_next_row = r_row + c_ONE;
            w_next_col = '0;
        end else if (w_row_zone == c_ZONE_MID && (r_col + c_ONE) == r_half) begin
            w_next_col = c_TILE_DIM + r_half;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (channel_group_done)
                    w_state_next = (w_half == '0) ? S_WAIT_NBR : S_READ;
            end
            S_READ: w_state_next = S_CAPTURE;
            S_CAPTURE: begin
                if (buffer_data_read == 8'd0) begin
                    w_advance    = 1'b1;
                    w_state_next = w_last ? S_WAIT_NBR : S_READ;
                end else begin
                    w_capture    = 1'b1;
                    w_state_next = S_XMIT;
                end
            end
            S_XMIT: begin
                if (neighbor_cts[r_dir]) begin
                    w_advance    = 1'b1;
                    w_state_next = w_last ? S_WAIT_NBR : S_READ;
                end
            end
            S_WAIT_NBR: begin
                if (&neighbor_exchange_done)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_half    <= '0;
            r_width   <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_dir     <= 3'd0;
            r_value   <= 8'd0;
            r_out_row <= '0;
            r_out_col <= '0;
        end else begin
            if (r_state == S_IDLE && channel_group_done) begin
                r_half  <= w_half;
                r_width <= c_TILE_DIM + (w_half << 1);
                r_row   <= '0;
                r_col   <= '0;
            end
            if (w_advance) begin
                r_row <= w_next_row;
                r_col <= w_next_col;
            end
            if (w_capture) begin
                r_value   <= buffer_data_read;
                r_dir     <= w_dir;
                r_out_row <= translate(r_row, w_row_zone);
                r_out_col <= translate(r_col, w_col_zone);
            end
        end
    end

    always_comb begin
        buffer_bank_read             = '0;
        buffer_bank_entry            = '0;
        neighbor_output_value        = '0;
        neighbor_output_row          = '0;
        neighbor_output_column       = '0;
        neighbor_output_write_enable = '0;
        exchange_done                = 1'b0;
        cycle_done                   = 1'b0;
        case (r_state)
            S_READ: begin
                buffer_bank_read  = w_index[c_BANK_W-1:0];
                buffer_bank_entry = w_index >> c_BANK_W;
            end
            S_XMIT: begin
                neighbor_output_value[r_dir]        = r_value;
                neighbor_output_row[r_dir]          = r_out_row;
                neighbor_output_column[r_dir]       = r_out_col;
                neighbor_output_write_enable[r_dir] = neighbor_cts[r_dir];
            end
            S_WAIT_NBR: begin
                exchange_done = 1'b1;
                cycle_done    = &neighbor_exchange_done;
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_neighbor_output_processor.sv
`default_nettype none
// Testbench for neighbor_output_processor: table of single-cell halo vectors
// plus hand-written sequences for all-zero scan, backpressure, H=0 and reset.
module tb_neighbor_output_processor;
    localparam int BC = 32;
    localparam int TS = 256;
    localparam int TD = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [2:0]       kernel_size = 3'd0;
    logic             channel_group_done = 1'b0;
    logic [4:0]       buffer_bank_read;
    logic [7:0]       buffer_bank_entry;
    logic [7:0]       buffer_data_read = 8'd0;
    logic [7:0]       neighbor_cts = 8'hFF;
    logic [7:0]       neighbor_exchange_done = 8'h00;
    logic [7:0][7:0]  neighbor_output_value;
    logic [7:0][7:0]  neighbor_output_row;
    logic [7:0][7:0]  neighbor_output_column;
    logic [7:0]       neighbor_output_write_enable;
    logic             exchange_done;
    logic             cycle_done;

    neighbor_output_processor #(.BANK_COUNT(BC), .TILE_SIZE(TS), .TILE_DIM(TD)) dut (
        .clk                          (clk),
        .reset_n                      (reset_n),
        .kernel_size                  (kernel_size),
        .channel_group_done           (channel_group_done),
        .buffer_bank_read             (buffer_bank_read),
        .buffer_bank_entry            (buffer_bank_entry),
        .buffer_data_read             (buffer_data_read),
        .neighbor_cts                 (neighbor_cts),
        .neighbor_exchange_done       (neighbor_exchange_done),
        .neighbor_output_value        (neighbor_output_value),
        .neighbor_output_row          (neighbor_output_row),
        .neighbor_output_column       (neighbor_output_column),
        .neighbor_output_write_enable (neighbor_output_write_enable),
        .exchange_done                (exchange_done),
        .cycle_done                   (cycle_done)
    );

    always #5 clk = ~clk;

    typedef struct { int dir; int value; int row; int col; } xfer_t;
    typedef struct {
        logic [2:0] k; int r; int c; logic [7:0] v;
        int dir; int row; int col; int bank; int entry; int cells;
    } vec_t;

    xfer_t      sb_q[$];
    vec_t       vecs[10];
    logic [7:0] mem [0:255];
    int n_checks = 0, n_pass = 0;
    int strobe_cnt = 0, interior_hits = 0, cur_half = 0;
    int got_bank = -1, got_entry = -1;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic int any_output();
        return int'(|{neighbor_output_value, neighbor_output_row, neighbor_output_column,
                      neighbor_output_write_enable, buffer_bank_read, buffer_bank_entry,
                      exchange_done, cycle_done});
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Buffer read port: data valid one cycle after the address.
    always @(posedge clk) begin
        int a;
        a = int'(buffer_bank_entry) * BC + int'(buffer_bank_read);
        buffer_data_read <= (a < 256) ? mem[a] : 8'h00;
    end

    // Monitor: scoreboard pops on every strobe, plus read-address bookkeeping.
    always @(negedge clk) begin
        if (!reset_n) begin
            int a, w, r, c, busy;
            xfer_t e;
            a = int'(buffer_bank_entry) * BC + int'(buffer_bank_read);
            w = TD + 2 * cur_half;
            if (a != 0) begin
                r = a / w;
                c = a % w;
                if (r >= cur_half && r < TD + cur_half && c >= cur_half && c < TD + cur_half)
                    interior_hits++;
            end
            if (a < 256 && mem[a] != 8'h00) begin
                got_bank  = int'(buffer_bank_read);
                got_entry = int'(buffer_bank_entry);
            end
            for (int d = 0; d < 8; d++) begin
                if (neighbor_output_write_enable[d]) begin
                    strobe_cnt++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_strobe", d, -1);
                    end else begin
                        e = sb_q.pop_front();
                        check("xfer_dir", d, e.dir);
                        check("xfer_value", int'(neighbor_output_value[d]), e.value);
                        check("xfer_row", int'(neighbor_output_row[d]), e.row);
                        check("xfer_col", int'(neighbor_output_column[d]), e.col);
                        busy = 0;
                        for (int o = 0; o < 8; o++)
                            if (o != d && (|{neighbor_output_value[o], neighbor_output_row[o],
                                             neighbor_output_column[o]}))
                                busy = 1;
                        check("idle_bus_zero", busy, 0);
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [2:0] k);
        cur_half = int'(k >> 1);
        @(negedge clk);
        kernel_size        = k;
        channel_group_done = 1'b1;
        @(negedge clk);
        channel_group_done = 1'b0;
        kernel_size        = 3'd0;
    endtask

    task automatic wait_exchange(output int lat);
        lat = 0;
        while (!exchange_done && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        if (!exchange_done) check("exchange_done_timeout", 0, 1);
    endtask

    task automatic handshake();
        int pulses;
        pulses = 0;
        neighbor_exchange_done = 8'h7F;
        repeat (3) begin
            @(negedge clk);
            if (cycle_done) pulses++;
        end
        check("partial_nbr_no_cycle_done", pulses, 0);
        check("exchange_done_hold", int'(exchange_done), 1);
        neighbor_exchange_done = 8'hFF;
        #1;
        check("cycle_done_pulse", int'(cycle_done), 1);
        @(negedge clk);
        check("cycle_done_single", int'(cycle_done), 0);
        check("exchange_done_fall", int'(exchange_done), 0);
        neighbor_exchange_done = 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat, s0, w, stable, we_seen, n, idle_bad;
        logic [191:0] snap;
        xfer_t e;

        //            k     r   c   value  dir row col bank entry cells
        vecs[0] = '{3'd3,  0,  0, 8'h5A, 7,  8,  8,  0,  0,  36};
        vecs[1] = '{3'd3,  4,  9, 8'h11, 2,  4,  1, 17,  1,  36};
        vecs[2] = '{3'd7, 13, 13, 8'h7F, 3,  5,  5,  3,  6, 132};
        vecs[3] = '{3'd3,  0,  5, 8'h22, 0,  8,  5,  5,  0,  36};
        vecs[4] = '{3'd3,  9,  0, 8'h33, 5,  1,  8, 26,  2,  36};
        vecs[5] = '{3'd3,  9,  4, 8'h44, 4,  1,  4, 30,  2,  36};
        vecs[6] = '{3'd3,  3,  0, 8'h55, 6,  3,  8, 30,  0,  36};
        vecs[7] = '{3'd3,  0,  9, 8'h66, 1,  8,  1,  9,  0,  36};
        vecs[8] = '{3'd5, 11,  1, 8'h77, 5,  3,  9,  5,  4,  80};
        vecs[9] = '{3'd7,  5,  2, 8'h88, 6,  5, 10,  8,  2, 132};

        clear_mem();
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", any_output(), 0);
        reset_n = 1'b0;

        // All-zero scan: 36 cells x 2 cycles, no strobes.
        s0 = strobe_cnt;
        interior_hits = 0;
        pulse_start(3'd3);
        wait_exchange(lat);
        check("zero_scan_latency", lat, 72);
        check("zero_scan_strobes", strobe_cnt - s0, 0);
        check("zero_scan_interior_reads", interior_hits, 0);
        handshake();

        foreach (vecs[i]) begin
            clear_mem();
            w = TD + 2 * int'(vecs[i].k >> 1);
            mem[vecs[i].r * w + vecs[i].c] = vecs[i].v;
            e.dir = vecs[i].dir; e.value = int'(vecs[i].v);
            e.row = vecs[i].row; e.col = vecs[i].col;
            sb_q.push_back(e);
            got_bank = -1; got_entry = -1;
            interior_hits = 0;
            s0 = strobe_cnt;
            pulse_start(vecs[i].k);
            wait_exchange(lat);
            check("vec_latency", lat, 2 * vecs[i].cells + 1);
            check("vec_strobes", strobe_cnt - s0, 1);
            check("vec_bank", got_bank, vecs[i].bank);
            check("vec_entry", got_entry, vecs[i].entry);
            check("vec_queue_empty", sb_q.size(), 0);
            check("vec_interior_reads", interior_hits, 0);
            handshake();
        end

        // Backpressure on the east neighbour.
        clear_mem();
        mem[49] = 8'h11;
        neighbor_cts = 8'hFB;
        e.dir = 2; e.value = 'h11; e.row = 4; e.col = 1;
        sb_q.push_back(e);
        s0 = strobe_cnt;
        pulse_start(3'd3);
        n = 0;
        while (neighbor_output_value[2] == 8'h00 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("bp_value_presented", int'(neighbor_output_value[2]), 'h11);
        snap = {neighbor_output_value, neighbor_output_row, neighbor_output_column};
        stable = 1; we_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if ({neighbor_output_value, neighbor_output_row, neighbor_output_column} != snap)
                stable = 0;
            if (|neighbor_output_write_enable) we_seen = 1;
        end
        check("bp_outputs_stable", stable, 1);
        check("bp_we_low_while_blocked", we_seen, 0);
        @(posedge clk);
        #1 neighbor_cts = 8'hFF;
        #1 check("bp_strobe_on_cts", int'(neighbor_output_write_enable), 'h04);
        wait_exchange(lat);
        check("bp_single_strobe", strobe_cnt - s0, 1);
        check("bp_queue_empty", sb_q.size(), 0);
        handshake();

        // H=0: straight to WAIT_NBR, no reads.
        s0 = strobe_cnt;
        got_bank = -1;
        pulse_start(3'd1);
        wait_exchange(lat);
        check("h0_latency", lat, 0);
        check("h0_no_reads", got_bank, -1);
        check("h0_strobes", strobe_cnt - s0, 0);
        handshake();

        // Reset asserted while stalled in XMIT.
        clear_mem();
        mem[0] = 8'h5A;
        neighbor_cts = 8'h7F;
        pulse_start(3'd3);
        n = 0;
        while (neighbor_output_value[7] == 8'h00 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst_value_presented", int'(neighbor_output_value[7]), 'h5A);
        #2 reset_n = 1'b1;
        #1 check("rst_outputs_zero_at_once", any_output(), 0);
        @(negedge clk);
        reset_n = 1'b0;
        neighbor_cts = 8'hFF;
        s0 = strobe_cnt;
        idle_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (any_output() != 0) idle_bad = 1;
        end
        check("rst_idle_after_release", idle_bad, 0);
        check("rst_no_strobe_after", strobe_cnt - s0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
